// File: rtl/seq_gen_pkg.sv
// Shared types for the sequence generator.
// Holds the FSM state encoding, the mode codes and the mode normaliser.
package seq_gen_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEED0 = 3'd1;
  localparam logic [2:0] ST_SEED1 = 3'd2;
  localparam logic [2:0] ST_CALC  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_SEED0 = ST_SEED0,
    S_SEED1 = ST_SEED1,
    S_CALC  = ST_CALC,
    S_DONE  = ST_DONE
  } state_t;

  localparam logic [1:0] MODE_FIB   = 2'b00;
  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_DBL   = 2'b10;

  // Mode 11 is an alias of Fibonacci.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_FIB : m;
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// Register file: NUM_REGS x DATA_W, one sync write, three async reads.
// Ports: Clk, Rst (async low clear), we/waddr/wdata, a/b/rd read ports.
module seq_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] b_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign a_data  = r_mem[a_addr];
  assign b_data  = r_mem[b_addr];
  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/seq_gen_fsm.sv
// Sequence generator: fills a register file with Fibonacci, arithmetic
// or doubling sequences. Ports: Clk, Rst (async low), start/busy/done
// handshake, mode, len, seed0, seed1, sticky ovf, count, rd_addr/rd_data.
module seq_gen_fsm
  import seq_gen_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 16,
  parameter int ADDR_W      = 4,
  parameter int STOP_ON_OVF = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] seed0,
  input  logic [DATA_W-1:0] seed1,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [ADDR_W:0]   count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W:0] LEN_MIN = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(NUM_REGS);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_mode;
  logic [ADDR_W:0]   r_len;
  logic [DATA_W-1:0] r_seed0;
  logic [DATA_W-1:0] r_seed1;
  logic [ADDR_W-1:0] r_idx;
  logic              r_ovf;
  logic [ADDR_W:0]   r_count;

  logic [ADDR_W:0]   w_len_clamp;
  logic [ADDR_W-1:0] w_a_addr;
  logic [ADDR_W-1:0] w_b_addr;
  logic [DATA_W-1:0] w_a_data;
  logic [DATA_W-1:0] w_b_data;
  logic [DATA_W-1:0] w_b_op;
  logic [DATA_W:0]   w_sum;
  logic              w_carry;
  logic              w_last;
  logic              w_stop;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  always_comb begin
    w_len_clamp = len;
    if (len < LEN_MIN) begin
      w_len_clamp = LEN_MIN;
    end else if (len > LEN_MAX) begin
      w_len_clamp = LEN_MAX;
    end
  end

  // Port a is always the previous entry; port b is two back for
  // Fibonacci and the previous entry again otherwise.
  assign w_a_addr = r_idx - ADDR_W'(1);
  assign w_b_addr = (r_mode == MODE_FIB) ? r_idx - ADDR_W'(2)
                                         : r_idx - ADDR_W'(1);
  assign w_b_op   = (r_mode == MODE_ARITH) ? r_seed1 : w_b_data;
  assign w_sum    = {1'b0, w_a_data} + {1'b0, w_b_op};
  assign w_carry  = w_sum[DATA_W];
  assign w_last   = ({1'b0, r_idx} == r_len - (ADDR_W+1)'(1));
  assign w_stop   = w_carry && (STOP_ON_OVF != 0);

  seq_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rf (
    .Clk     (Clk),
    .Rst     (Rst),
    .we      (w_we),
    .waddr   (w_waddr),
    .wdata   (w_wdata),
    .a_addr  (w_a_addr),
    .b_addr  (w_b_addr),
    .rd_addr (rd_addr),
    .a_data  (w_a_data),
    .b_data  (w_b_data),
    .rd_data (rd_data)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = r_idx;
    w_wdata = w_sum[DATA_W-1:0];
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SEED0;
      end
      S_SEED0: begin
        w_we    = 1'b1;
        w_waddr = '0;
        w_wdata = r_seed0;
        w_next  = (r_mode == MODE_FIB) ? S_SEED1 : S_CALC;
      end
      S_SEED1: begin
        w_we    = 1'b1;
        w_waddr = ADDR_W'(1);
        w_wdata = r_seed1;
        w_next  = (r_len == LEN_MIN) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (w_stop) begin
          w_next = S_DONE;
        end else begin
          w_we = 1'b1;
          if (w_last) w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_mode  <= MODE_FIB;
      r_len   <= '0;
      r_seed0 <= '0;
      r_seed1 <= '0;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (start) begin
          r_mode  <= norm_mode(mode);
          r_len   <= w_len_clamp;
          r_seed0 <= seed0;
          r_seed1 <= seed1;
          r_ovf   <= 1'b0;
          r_count <= '0;
        end
      end else if (r_state == S_SEED0) begin
        r_idx <= ADDR_W'(1);
      end else if (r_state == S_SEED1) begin
        r_idx <= ADDR_W'(2);
        if (r_len == LEN_MIN) r_count <= r_len;
      end else if (r_state == S_CALC) begin
        if (w_carry) r_ovf <= 1'b1;
        if (w_stop) begin
          r_count <= {1'b0, r_idx};
        end else if (w_last) begin
          r_count <= r_len;
        end else begin
          r_idx <= r_idx + ADDR_W'(1);
        end
      end
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign ovf   = r_ovf;
  assign count = r_count;

endmodule
